// File: rtl/gcd_subtractor_if.sv
// Operand/result bundle between the GCD controller and its subtractor step.
// The master side presents operand pairs; the slave side returns both
// differences, the compare flags and a valid qualifier.
interface gcd_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] a_sub;
  logic [WIDTH-1:0] b_sub;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             valid_o;

  // Controller side: drives operands, consumes results.
  modport master (
    output valid_i, a_i, b_i,
    input  a_sub, b_sub, a_lt_b, a_eq_b, valid_o
  );

  // Subtractor side: consumes operands, drives results.
  modport slave (
    input  valid_i, a_i, b_i,
    output a_sub, b_sub, a_lt_b, a_eq_b, valid_o
  );
endinterface

// File: rtl/gcd_subtractor.sv
// Dual-direction subtractor for the GCD datapath. Every accepted operand pair
// produces a-b, b-a (both modulo 2^WIDTH) plus less-than and equal flags,
// registered with one cycle of latency. Results hold while no pair is valid.
module gcd_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gcd_subtractor_if.slave    bus
);

  logic [WIDTH:0]   diff_ab_d;
  logic [WIDTH-1:0] a_sub_d;
  logic [WIDTH-1:0] b_sub_d;
  logic             a_lt_b_d;
  logic             a_eq_b_d;

  logic [WIDTH-1:0] a_sub_q;
  logic [WIDTH-1:0] b_sub_q;
  logic             a_lt_b_q;
  logic             a_eq_b_q;
  logic             valid_q;

  // Combinational differences; the extra MSB of a-b is the borrow, i.e. a<b.
  always_comb begin
    diff_ab_d = {1'b0, bus.a_i} - {1'b0, bus.b_i};
    a_sub_d   = diff_ab_d[WIDTH-1:0];
    b_sub_d   = bus.b_i - bus.a_i;
    a_lt_b_d  = diff_ab_d[WIDTH];
    a_eq_b_d  = (bus.a_i == bus.b_i);
  end

  // Result registers: load only on a valid pair so idle-cycle inputs (even X)
  // never reach the outputs; valid tracks valid_i every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sub_q  <= '0;
      b_sub_q  <= '0;
      a_lt_b_q <= 1'b0;
      a_eq_b_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        a_sub_q  <= a_sub_d;
        b_sub_q  <= b_sub_d;
        a_lt_b_q <= a_lt_b_d;
        a_eq_b_q <= a_eq_b_d;
      end
    end
  end

  assign bus.a_sub   = a_sub_q;
  assign bus.b_sub   = b_sub_q;
  assign bus.a_lt_b  = a_lt_b_q;
  assign bus.a_eq_b  = a_eq_b_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_gcd_subtractor.sv
// Directed bench for gcd_subtractor: reset behaviour, wrap boundaries,
// equal operands, hold on idle, back-to-back throughput and a 16-bit instance.
module tb_gcd_subtractor;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  gcd_subtractor_if #(.WIDTH(8))  if8  ();
  gcd_subtractor_if #(.WIDTH(16)) if16 ();

  gcd_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  gcd_subtractor #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every 8-bit output against hand-computed values.
  task automatic check8(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic elt, input logic eeq, input logic ev);
    check({tag, ".a_sub"},   64'(if8.a_sub),   64'(ea));
    check({tag, ".b_sub"},   64'(if8.b_sub),   64'(eb));
    check({tag, ".a_lt_b"},  64'(if8.a_lt_b),  64'(elt));
    check({tag, ".a_eq_b"},  64'(if8.a_eq_b),  64'(eeq));
    check({tag, ".valid_o"}, 64'(if8.valid_o), 64'(ev));
  endtask

  // Drive one 8-bit pair between edges, then sample just after the capturing edge.
  task automatic apply8(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if8.valid_i = v;
    if8.a_i     = a;
    if8.b_i     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int         ea;
    int         eb;
    n_tests = 0;
    n_fail  = 0;

    // Reset held while a valid pair is presented: nothing is captured.
    rst_n        = 1'b0;
    if8.valid_i  = 1'b1;
    if8.a_i      = 8'd5;
    if8.b_i      = 8'd3;
    if16.valid_i = 1'b0;
    if16.a_i     = '0;
    if16.b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_hold", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset hold: a_sub=%0d b_sub=%0d valid_o=%0b", if8.a_sub, if8.b_sub, if8.valid_o);

    // Release at a falling edge; the pair is taken on the first edge with rst_n=1.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check8("first_capture", 8'd2, 8'd254, 1'b0, 1'b0, 1'b1);
    $display("[TB] 5-3: a_sub=%0d b_sub=%0d lt=%0b eq=%0b", if8.a_sub, if8.b_sub, if8.a_lt_b, if8.a_eq_b);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_clear", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    $display("[TB] async reset mid-cycle: valid_o=%0b a_sub=%0d", if8.valid_o, if8.a_sub);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap boundary: 0 - 255.
    apply8(1'b1, 8'd0, 8'd255);
    check8("wrap_0_255", 8'd1, 8'd255, 1'b1, 1'b0, 1'b1);
    $display("[TB] 0-255: a_sub=%0d b_sub=%0d lt=%0b", if8.a_sub, if8.b_sub, if8.a_lt_b);

    // Equal operands.
    apply8(1'b1, 8'd77, 8'd77);
    check8("equal_77", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    $display("[TB] 77-77: a_sub=%0d eq=%0b", if8.a_sub, if8.a_eq_b);

    // Reverse boundary: 255 - 0.
    apply8(1'b1, 8'd255, 8'd0);
    check8("wrap_255_0", 8'd255, 8'd1, 1'b0, 1'b0, 1'b1);
    $display("[TB] 255-0: a_sub=%0d b_sub=%0d lt=%0b", if8.a_sub, if8.b_sub, if8.a_lt_b);

    // Both zero.
    apply8(1'b1, 8'd0, 8'd0);
    check8("zero_zero", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    $display("[TB] 0-0: eq=%0b", if8.a_eq_b);

    // Hold: capture 200-13, then idle cycles with junk operands.
    apply8(1'b1, 8'd200, 8'd13);
    check8("hold_cap", 8'd187, 8'd69, 1'b0, 1'b0, 1'b1);
    $display("[TB] 200-13: a_sub=%0d b_sub=%0d", if8.a_sub, if8.b_sub);
    for (int i = 0; i < 3; i++) begin
      apply8(1'b0, 8'($urandom), 8'($urandom));
      check8($sformatf("hold_idle%0d", i), 8'd187, 8'd69, 1'b0, 1'b0, 1'b0);
      $display("[TB] idle %0d: a_sub=%0d b_sub=%0d valid_o=%0b", i, if8.a_sub, if8.b_sub, if8.valid_o);
    end

    // Back-to-back random pairs; expectations from plain integer arithmetic.
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 50) rb = ra;
      ea = (int'(ra) + 256 - int'(rb)) % 256;
      eb = (int'(rb) + 256 - int'(ra)) % 256;
      apply8(1'b1, ra, rb);
      check8($sformatf("b2b%0d", i), 8'(ea), 8'(eb), ra < rb, ra == rb, 1'b1);
      $display("[TB] b2b %0d: %0d-%0d a_sub=%0d b_sub=%0d lt=%0b eq=%0b",
               i, ra, rb, if8.a_sub, if8.b_sub, if8.a_lt_b, if8.a_eq_b);
    end
    @(negedge clk);
    if8.valid_i = 1'b0;

    // 16-bit instance: 0x0001 - 0xFFFF.
    @(negedge clk);
    if16.valid_i = 1'b1;
    if16.a_i     = 16'h0001;
    if16.b_i     = 16'hFFFF;
    @(posedge clk);
    #1;
    check("w16.a_sub",   64'(if16.a_sub),   64'h0002);
    check("w16.b_sub",   64'(if16.b_sub),   64'hFFFE);
    check("w16.a_lt_b",  64'(if16.a_lt_b),  64'd1);
    check("w16.a_eq_b",  64'(if16.a_eq_b),  64'd0);
    check("w16.valid_o", 64'(if16.valid_o), 64'd1);
    $display("[TB] w16 1-FFFF: a_sub=0x%0h b_sub=0x%0h lt=%0b", if16.a_sub, if16.b_sub, if16.a_lt_b);
    @(negedge clk);
    if16.valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("w16.idle_valid", 64'(if16.valid_o), 64'd0);
    check("w16.idle_hold",  64'(if16.a_sub),   64'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
